// File: rtl/fpu_mem_responder_if.sv
// FPU load/store bus: level requests held by the FPU until a one-cycle ready pulse.
// master = FPU side, slave = memory responder side.
interface fpu_mem_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata, mem_ready, mem_err
  );
endinterface

// File: rtl/fpu_mem_responder.sv
// Word-addressed RAM answering FPU loads/stores after LATENCY cycles (1..15), with error flagging.
// One request in flight; requests arriving in WAIT/RESP are ignored, the FPU holds them until ready.
module fpu_mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  fpu_mem_responder_if.slave  mem,
  input  logic                init_we,
  input  logic [ADDR_W-1:0]   init_addr,
  input  logic [31:0]         init_data,
  output logic                busy,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    wr_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               re_q, re_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CNT_W-1:0]   rd_count_q, rd_count_d;
  logic [CNT_W-1:0]   wr_count_q, wr_count_d;

  logic [31:0]        ram [2**ADDR_W];

  logic               in_idle;
  logic               accept;
  logic               enter_resp;
  logic               init_ok;
  logic               cur_re, cur_we, cur_err;
  logic [31:0]        cur_addr, cur_wdata;
  logic [ADDR_W-1:0]  cur_idx;
  logic               ram_we;

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle && (mem.mem_re || mem.mem_we);
  assign init_ok = in_idle && init_we;

  // With LATENCY=1 the response edge is the acceptance edge, so the live bus is used there.
  always_comb begin
    cur_re    = in_idle ? mem.mem_re    : re_q;
    cur_we    = in_idle ? mem.mem_we    : we_q;
    cur_addr  = in_idle ? mem.mem_addr  : addr_q;
    cur_wdata = in_idle ? mem.mem_wdata : wdata_q;
    cur_idx   = cur_addr[ADDR_W+1:2];
    cur_err   = (cur_re && cur_we) || (cur_addr[1:0] != 2'b00)
                || ((cur_addr >> (ADDR_W + 2)) != 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    re_d       = re_q;
    we_d       = we_q;
    err_d      = err_q;
    rdata_d    = 32'd0;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    ram_we     = 1'b0;

    if (accept) begin
      cnt_d   = LAT_M1;
      addr_d  = mem.mem_addr;
      wdata_d = mem.mem_wdata;
      re_d    = mem.mem_re;
      we_d    = mem.mem_we;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (enter_resp) begin
      err_d = cur_err;
      if (!cur_err) begin
        if (cur_we) begin
          ram_we = 1'b1;
          if (wr_count_q != {CNT_W{1'b1}}) wr_count_d = wr_count_q + 1'b1;
        end else begin
          // A preload landing on the same edge must be visible to the read.
          rdata_d = (init_ok && (init_addr == cur_idx)) ? init_data : ram[cur_idx];
          if (rd_count_q != {CNT_W{1'b1}}) rd_count_d = rd_count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      re_q       <= re_d;
      we_q       <= we_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Contents survive reset; an FPU store on the same edge as a preload wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_ok) ram[init_addr] <= init_data;
      if (ram_we)  ram[cur_idx]   <= cur_wdata;
    end
  end

  always_comb begin
    mem.mem_ready = (state_q == RESP);
    mem.mem_err   = (state_q == RESP) && err_q;
    mem.mem_rdata = rdata_q;
    busy          = (state_q != IDLE);
    rd_count      = rd_count_q;
    wr_count      = wr_count_q;
  end

endmodule

// File: tb/tb_fpu_mem_responder.sv
// Directed bench: three responders (LATENCY 1/3/4, the first with 4-bit counters to reach saturation).
module tb_fpu_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        re    [3];
  logic        we    [3];
  logic        iwe   [3];
  logic [11:0] iaddr [3];
  logic [31:0] idata [3];
  logic [31:0] rdata [3];
  logic        rdy   [3];
  logic        err   [3];
  logic        bsy   [3];
  logic [15:0] rc    [3];
  logic [15:0] wc    [3];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    localparam int CW  = (g == 0) ? 4 : 16;
    logic [CW-1:0] rcn, wcn;
    fpu_mem_responder_if bus ();
    assign bus.mem_addr  = addr[g];
    assign bus.mem_wdata = wdata[g];
    assign bus.mem_re    = re[g];
    assign bus.mem_we    = we[g];
    fpu_mem_responder #(.ADDR_W(12), .LATENCY(LAT), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst[g]), .mem(bus),
      .init_we(iwe[g]), .init_addr(iaddr[g]), .init_data(idata[g]),
      .busy(bsy[g]), .rd_count(rcn), .wr_count(wcn)
    );
    assign rdata[g] = bus.mem_rdata;
    assign rdy[g]   = bus.mem_ready;
    assign err[g]   = bus.mem_err;
    assign rc[g]    = 16'(rcn);
    assign wc[g]    = 16'(wcn);
  end

  // Issue one request, hold it until ready (max 40 edges); lat=0 means no ready seen.
  task automatic xact(input int s, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic [31:0] rd,
                      output logic er, output logic bz);
    lat = 0; rd = '0; er = 1'b0; bz = 1'b1;
    @(negedge clk);
    re[s] = r; we[s] = w; addr[s] = a; wdata[s] = d;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin addr[s] = ~a; wdata[s] = ~d; end
      if (!bsy[s]) bz = 1'b0;
      if (rdy[s]) begin lat = k; rd = rdata[s]; er = err[s]; break; end
    end
    re[s] = 1'b0; we[s] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic preload(input int s, input logic [11:0] idx, input logic [31:0] d);
    @(negedge clk);
    iwe[s] = 1'b1; iaddr[s] = idx; idata[s] = d;
    @(posedge clk); #1;
    iwe[s] = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      rst[s] = 1'b1; re[s] = 1'b0; we[s] = 1'b0; iwe[s] = 1'b0;
      addr[s] = '0; wdata[s] = '0; iaddr[s] = '0; idata[s] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) rst[s] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n_checks++; if (rdy[s] !== 1'b0) begin n_errors++; $display("FAIL reset_ready[%0d]: got %b want 0", s, rdy[s]); end
      n_checks++; if (err[s] !== 1'b0) begin n_errors++; $display("FAIL reset_err[%0d]: got %b want 0", s, err[s]); end
      n_checks++; if (rdata[s] !== 32'd0) begin n_errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", s, rdata[s]); end
      n_checks++; if (bsy[s] !== 1'b0) begin n_errors++; $display("FAIL reset_busy[%0d]: got %b want 0", s, bsy[s]); end
      n_checks++; if (rc[s] !== 16'd0) begin n_errors++; $display("FAIL reset_rd_count[%0d]: got %0d want 0", s, rc[s]); end
      n_checks++; if (wc[s] !== 16'd0) begin n_errors++; $display("FAIL reset_wr_count[%0d]: got %0d want 0", s, wc[s]); end
    end
  endtask

  task automatic test_basic_read();
    int lat; logic [31:0] rd; logic er, bz;
    preload(0, 12'd4, 32'h3F800000);
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rd, er, bz);
    n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL l1_latency: got %0d want 1", lat); end
    n_checks++; if (rd !== 32'h3F800000) begin n_errors++; $display("FAIL l1_rdata: got %h want 3f800000", rd); end
    n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL l1_err: got %b want 0", er); end
    n_checks++; if (rc[0] !== 16'd1) begin n_errors++; $display("FAIL l1_rd_count: got %0d want 1", rc[0]); end
    n_checks++; if (rdy[0] !== 1'b0) begin n_errors++; $display("FAIL l1_ready_drop: got %b want 0", rdy[0]); end
    n_checks++; if (rdata[0] !== 32'd0) begin n_errors++; $display("FAIL l1_rdata_drop: got %h want 0", rdata[0]); end
  endtask

  task automatic test_latency_rw();
    int lat; logic [31:0] rd; logic er, bz;
    xact(1, 1'b0, 1'b1, 32'h20, 32'h40490FDB, lat, rd, er, bz);
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL l3_wr_latency: got %0d want 3", lat); end
    n_checks++; if (bz !== 1'b1) begin n_errors++; $display("FAIL l3_wr_busy: got %b want 1", bz); end
    n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL l3_wr_err: got %b want 0", er); end
    n_checks++; if (wc[1] !== 16'd1) begin n_errors++; $display("FAIL l3_wr_count: got %0d want 1", wc[1]); end
    xact(1, 1'b1, 1'b0, 32'h20, 32'h0, lat, rd, er, bz);
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL l3_rd_latency: got %0d want 3", lat); end
    n_checks++; if (bz !== 1'b1) begin n_errors++; $display("FAIL l3_rd_busy: got %b want 1", bz); end
    n_checks++; if (rd !== 32'h40490FDB) begin n_errors++; $display("FAIL l3_rd_data: got %h want 40490fdb", rd); end
    n_checks++; if (rc[1] !== 16'd1) begin n_errors++; $display("FAIL l3_rd_count: got %0d want 1", rc[1]); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, bz;
    preload(1, 12'd0, 32'hA5A5A5A5);
    xact(1, 1'b1, 1'b0, 32'h22, 32'h0, lat, rd, er, bz);
    n_checks++; if (lat !== 3 || er !== 1'b1) begin n_errors++; $display("FAIL err_misaligned: got lat=%0d err=%b want lat=3 err=1", lat, er); end
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL err_misaligned_rdata: got %h want 0", rd); end
    xact(1, 1'b0, 1'b1, 32'h00004000, 32'hFFFFFFFF, lat, rd, er, bz);
    n_checks++; if (lat !== 3 || er !== 1'b1) begin n_errors++; $display("FAIL err_range: got lat=%0d err=%b want lat=3 err=1", lat, er); end
    xact(1, 1'b1, 1'b1, 32'h20, 32'h0, lat, rd, er, bz);
    n_checks++; if (lat !== 3 || er !== 1'b1) begin n_errors++; $display("FAIL err_both: got lat=%0d err=%b want lat=3 err=1", lat, er); end
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL err_both_rdata: got %h want 0", rd); end
    n_checks++; if (rc[1] !== 16'd1 || wc[1] !== 16'd1) begin n_errors++; $display("FAIL err_counts: got rd=%0d wr=%0d want 1 1", rc[1], wc[1]); end
    xact(1, 1'b1, 1'b0, 32'h0, 32'h0, lat, rd, er, bz);
    n_checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin n_errors++; $display("FAIL err_word0_kept: got %h err=%b want a5a5a5a5 0", rd, er); end
    xact(1, 1'b1, 1'b0, 32'h20, 32'h0, lat, rd, er, bz);
    n_checks++; if (rd !== 32'h40490FDB) begin n_errors++; $display("FAIL err_word8_kept: got %h want 40490fdb", rd); end
    n_checks++; if (rc[1] !== 16'd3) begin n_errors++; $display("FAIL err_rd_count_after: got %0d want 3", rc[1]); end
  endtask

  task automatic test_held_request();
    logic [29:0] pat0;
    logic [11:0] pat1;
    pat0 = '0; pat1 = '0;
    @(negedge clk);
    re[0] = 1'b1; addr[0] = 32'h0;
    re[1] = 1'b1; addr[1] = 32'h0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      pat0[k] = rdy[0];
      if (k < 12) pat1[k] = rdy[1];
      if (k == 11) re[1] = 1'b0;
    end
    re[0] = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (pat0 !== 30'h15555555) begin n_errors++; $display("FAIL held_l1_pattern: got %b want %b", pat0, 30'h15555555); end
    n_checks++; if (pat1 !== 12'h444) begin n_errors++; $display("FAIL held_l3_pattern: got %b want %b", pat1, 12'h444); end
    n_checks++; if (rc[0] !== 16'd15) begin n_errors++; $display("FAIL held_l1_saturate: got %0d want 15", rc[0]); end
    n_checks++; if (rc[1] !== 16'd6) begin n_errors++; $display("FAIL held_l3_rd_count: got %0d want 6", rc[1]); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er, bz; logic seen;
    preload(2, 12'd12, 32'h12345678);
    @(negedge clk);
    we[2] = 1'b1; addr[2] = 32'h30; wdata[2] = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (bsy[2] !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy_wait: got %b want 1", bsy[2]); end
    @(negedge clk);
    rst[2] = 1'b1; we[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    n_checks++; if (rdy[2] !== 1'b0 || err[2] !== 1'b0 || bsy[2] !== 1'b0) begin n_errors++; $display("FAIL rstmid_ctrl: got rdy=%b err=%b busy=%b want 0 0 0", rdy[2], err[2], bsy[2]); end
    n_checks++; if (rdata[2] !== 32'd0) begin n_errors++; $display("FAIL rstmid_rdata: got %h want 0", rdata[2]); end
    n_checks++; if (rc[2] !== 16'd0 || wc[2] !== 16'd0) begin n_errors++; $display("FAIL rstmid_counts: got rd=%0d wr=%0d want 0 0", rc[2], wc[2]); end
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (rdy[2]) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_ready: got %b want 0", seen); end
    xact(2, 1'b1, 1'b0, 32'h30, 32'h0, lat, rd, er, bz);
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL rstmid_l4_latency: got %0d want 4", lat); end
    n_checks++; if (rd !== 32'h12345678) begin n_errors++; $display("FAIL rstmid_ram_kept: got %h want 12345678", rd); end
    n_checks++; if (wc[2] !== 16'd0 || rc[2] !== 16'd1) begin n_errors++; $display("FAIL rstmid_counts_after: got rd=%0d wr=%0d want 1 0", rc[2], wc[2]); end
  endtask

  task automatic test_preload_overlap();
    int lat; logic [31:0] rd; logic er, bz; logic [31:0] got;
    @(negedge clk);
    iwe[0] = 1'b1; iaddr[0] = 12'd2; idata[0] = 32'h11111111;
    re[0] = 1'b1; addr[0] = 32'h8;
    @(posedge clk); #1;
    n_checks++; if (rdy[0] !== 1'b1 || rdata[0] !== 32'h11111111) begin n_errors++; $display("FAIL ovl_l1_fwd: got rdy=%b data=%h want 1 11111111", rdy[0], rdata[0]); end
    iwe[0] = 1'b0; re[0] = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (rc[0] !== 16'd15) begin n_errors++; $display("FAIL ovl_l1_no_wrap: got %0d want 15", rc[0]); end

    @(negedge clk);
    iwe[1] = 1'b1; iaddr[1] = 12'd2; idata[1] = 32'h11111111;
    re[1] = 1'b1; addr[1] = 32'h8;
    got = 32'hX; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      iwe[1] = 1'b0;
      if (rdy[1]) begin lat = k; got = rdata[1]; break; end
    end
    re[1] = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (lat !== 3 || got !== 32'h11111111) begin n_errors++; $display("FAIL ovl_l3_same_cycle: got lat=%0d data=%h want 3 11111111", lat, got); end

    @(negedge clk);
    re[1] = 1'b1; addr[1] = 32'h8;
    @(posedge clk); #1;
    iwe[1] = 1'b1; iaddr[1] = 12'd2; idata[1] = 32'h22222222;
    @(posedge clk); #1;
    iwe[1] = 1'b0;
    got = 32'hX;
    for (int k = 0; k < 20; k++) begin
      if (rdy[1]) begin got = rdata[1]; break; end
      @(posedge clk); #1;
    end
    re[1] = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (got !== 32'h11111111) begin n_errors++; $display("FAIL ovl_wait_preload_read: got %h want 11111111", got); end
    xact(1, 1'b1, 1'b0, 32'h8, 32'h0, lat, rd, er, bz);
    n_checks++; if (rd !== 32'h11111111 || er !== 1'b0) begin n_errors++; $display("FAIL ovl_wait_preload_ignored: got %h err=%b want 11111111 0", rd, er); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_latency_rw();
    test_errors();
    test_held_request();
    test_reset_mid();
    test_preload_overlap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
